reflet_ram_dp: RTL and testbench

REFLET_RAM_DP -- requirements
Module: reflet_ram_dp

---
 rtl/reflet_ram_pkg.sv | 14 +
 rtl/reflet_ram_sweeper.sv | 68 ++++++
 rtl/reflet_ram_dp.sv | 95 +++++++++
 tb/tb_reflet_ram_dp.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/reflet_ram_pkg.sv
// Shared definitions for the reflet RAM family: control FSM encoding and byte-mask sizing.
package reflet_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } ram_state_t;

  function automatic int mask_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/reflet_ram_sweeper.sv
// Post-reset control: optionally walks every word once writing zero, then reports ready.
module reflet_ram_sweeper
  import reflet_ram_pkg::*;
#(
  parameter int addr_size      = 8,
  parameter int size           = 256,
  parameter int clear_on_reset = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 ready,
  output logic                 clear_we,
  output logic [addr_size-1:0] clear_addr
);

  // One extra bit so the counter can represent size itself without wrapping.
  localparam int               CNT_W       = $clog2(size + 1);
  localparam logic [CNT_W-1:0] LAST_ADDR   = CNT_W'(size - 1);
  localparam ram_state_t       RESET_STATE = (clear_on_reset != 0) ? ST_CLEAR : ST_IDLE;
  localparam logic             RESET_WE    = (clear_on_reset != 0);

  ram_state_t       state_r;
  logic [CNT_W-1:0] count_r;
  logic             ready_r;
  logic             clear_we_r;

  // Control FSM: CLEAR sweeps 0..size-1 one word per cycle, IDLE skips straight to READY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= RESET_STATE;
      count_r    <= '0;
      ready_r    <= 1'b0;
      clear_we_r <= RESET_WE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r    <= ST_READY;
          ready_r    <= 1'b1;
          clear_we_r <= 1'b0;
        end
        ST_CLEAR: begin
          if (count_r == LAST_ADDR) begin
            state_r    <= ST_READY;
            ready_r    <= 1'b1;
            clear_we_r <= 1'b0;
          end else begin
            count_r <= count_r + CNT_W'(1);
          end
        end
        ST_READY: begin
          ready_r    <= 1'b1;
          clear_we_r <= 1'b0;
        end
        default: begin
          state_r    <= RESET_STATE;
          count_r    <= '0;
          ready_r    <= 1'b0;
          clear_we_r <= RESET_WE;
        end
      endcase
    end
  end

  assign ready      = ready_r;
  assign clear_we   = clear_we_r;
  assign clear_addr = addr_size'(count_r);

endmodule

// File: rtl/reflet_ram_dp.sv
// True dual-port RAM with byte write masks, read-first ports and an optional zeroing sweep.
module reflet_ram_dp
  import reflet_ram_pkg::*;
#(
  parameter int data_width     = 16,
  parameter int addr_size      = 8,
  parameter int size           = 256,
  parameter int clear_on_reset = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    ready,
  input  logic                    en_a,
  input  logic [addr_size-1:0]    addr_a,
  input  logic [data_width/8-1:0] wmask_a,
  input  logic [data_width-1:0]   data_in_a,
  output logic [data_width-1:0]   data_out_a,
  input  logic                    en_b,
  input  logic [addr_size-1:0]    addr_b,
  input  logic [data_width/8-1:0] wmask_b,
  input  logic [data_width-1:0]   data_in_b,
  output logic [data_width-1:0]   data_out_b
);

  localparam int             NB     = mask_width(data_width);
  localparam int             ADDR_X = addr_size + 1;
  localparam logic [addr_size:0] SIZE_L = ADDR_X'(size);

  logic [data_width-1:0] mem_r [size];

  logic                  ready_s;
  logic                  clear_we_s;
  logic [addr_size-1:0]  clear_addr_s;
  logic                  valid_a_s, valid_b_s;
  logic                  we_a_s, we_b_s, same_s;
  logic [data_width-1:0] wbits_a_s, wbits_b_s;
  logic [data_width-1:0] word_a_s, word_b_s;

  reflet_ram_sweeper #(
    .addr_size      (addr_size),
    .size           (size),
    .clear_on_reset (clear_on_reset)
  ) u_sweeper (
    .clk        (clk),
    .reset      (reset),
    .ready      (ready_s),
    .clear_we   (clear_we_s),
    .clear_addr (clear_addr_s)
  );

  assign ready     = ready_s;
  assign valid_a_s = ready_s && en_a && ({1'b0, addr_a} < SIZE_L);
  assign valid_b_s = ready_s && en_b && ({1'b0, addr_b} < SIZE_L);
  assign we_a_s    = valid_a_s && (|wmask_a);
  assign we_b_s    = valid_b_s && (|wmask_b);
  assign same_s    = we_a_s && we_b_s && (addr_a == addr_b);

  // Byte mask expansion and merge; on a shared address A's bytes are laid over B's result.
  always_comb begin
    wbits_a_s = '0;
    wbits_b_s = '0;
    for (int i = 0; i < NB; i++) begin
      wbits_a_s[8*i +: 8] = {8{wmask_a[i]}};
      wbits_b_s[8*i +: 8] = {8{wmask_b[i]}};
    end
    word_b_s = (mem_r[addr_b] & ~wbits_b_s) | (data_in_b & wbits_b_s);
    if (same_s) begin
      word_a_s = (word_b_s & ~wbits_a_s) | (data_in_a & wbits_a_s);
    end else begin
      word_a_s = (mem_r[addr_a] & ~wbits_a_s) | (data_in_a & wbits_a_s);
    end
  end

  // Storage update: the sweep owns the array while clearing, the ports only once ready.
  always_ff @(posedge clk) begin
    if (clear_we_s) begin
      mem_r[clear_addr_s] <= '0;
    end else begin
      if (we_b_s) mem_r[addr_b] <= word_b_s;
      if (we_a_s) mem_r[addr_a] <= word_a_s;
    end
  end

  // Registered read ports: old word on read-during-write, zero after an invalid access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_a <= '0;
      data_out_b <= '0;
    end else begin
      if (en_a) data_out_a <= valid_a_s ? mem_r[addr_a] : '0;
      if (en_b) data_out_b <= valid_b_s ? mem_r[addr_b] : '0;
    end
  end

endmodule

// File: tb/tb_reflet_ram_dp.sv
// Randomized self-checking bench for reflet_ram_dp against a word-array reference model.
module tb_reflet_ram_dp;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        ready, en_a, en_b;
  logic [7:0]  addr_a, addr_b;
  logic [1:0]  wmask_a, wmask_b;
  logic [15:0] data_in_a, data_in_b, data_out_a, data_out_b;

  logic        ready2, en2_a, en2_b;
  logic [7:0]  addr2_a, addr2_b;
  logic [1:0]  wmask2_a, wmask2_b;
  logic [15:0] din2_a, din2_b, dout2_a, dout2_b;

  logic [15:0] mem_m  [256];
  logic [15:0] mem2_m [200];
  bit          known2 [200];
  logic [15:0] exp_a, exp_b, exp2_a;
  int          n_total = 0;
  int          n_pass  = 0;

  reflet_ram_dp dut (
    .clk(clk), .reset(reset), .ready(ready),
    .en_a(en_a), .addr_a(addr_a), .wmask_a(wmask_a), .data_in_a(data_in_a), .data_out_a(data_out_a),
    .en_b(en_b), .addr_b(addr_b), .wmask_b(wmask_b), .data_in_b(data_in_b), .data_out_b(data_out_b)
  );

  reflet_ram_dp #(.data_width(16), .addr_size(8), .size(200), .clear_on_reset(0)) dut200 (
    .clk(clk), .reset(reset), .ready(ready2),
    .en_a(en2_a), .addr_a(addr2_a), .wmask_a(wmask2_a), .data_in_a(din2_a), .data_out_a(dout2_a),
    .en_b(en2_b), .addr_b(addr2_b), .wmask_b(wmask2_b), .data_in_b(din2_b), .data_out_b(dout2_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
  endtask

  // One clock on the default instance: model predicts read-first data, then applies B then A bytes.
  task automatic cyc(input logic ea, input logic [7:0] aa, input logic [1:0] ma, input logic [15:0] da,
                     input logic eb, input logic [7:0] ab, input logic [1:0] mb, input logic [15:0] db);
    en_a = ea; addr_a = aa; wmask_a = ma; data_in_a = da;
    en_b = eb; addr_b = ab; wmask_b = mb; data_in_b = db;
    if (ea) exp_a = mem_m[aa];
    if (eb) exp_b = mem_m[ab];
    for (int i = 0; i < 2; i++) begin
      if (eb && mb[i]) mem_m[ab][8*i +: 8] = db[8*i +: 8];
      if (ea && ma[i]) mem_m[aa][8*i +: 8] = da[8*i +: 8];
    end
    @(posedge clk); #1;
    check("ready_high", ready, 1);
    check($sformatf("port_a@%0d", aa), data_out_a, exp_a);
    check($sformatf("port_b@%0d", ab), data_out_b, exp_b);
  endtask

  // One clock on the size-200 instance, port A only; addresses >= 200 read as zero and never write.
  task automatic cyc2(input logic [7:0] aa, input logic [1:0] ma, input logic [15:0] da);
    bit chk;
    en2_a = 1'b1; addr2_a = aa; wmask2_a = ma; din2_a = da;
    chk = 1'b1;
    if (aa < 8'd200) begin
      chk = known2[aa];
      exp2_a = mem2_m[aa];
      for (int i = 0; i < 2; i++)
        if (ma[i]) mem2_m[aa][8*i +: 8] = da[8*i +: 8];
      if (ma == 2'b11) known2[aa] = 1'b1;
    end else begin
      exp2_a = 16'h0000;
    end
    @(posedge clk); #1;
    if (chk) check($sformatf("p200_a@%0d", aa), dout2_a, exp2_a);
  endtask

  task automatic wait_ready(input int start, input string tag);
    int n;
    n = start;
    while (ready !== 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, n, 256);
  endtask

  initial begin
    reset = 1'b1;
    en_a = 1'b0; addr_a = 8'd0; wmask_a = 2'b00; data_in_a = 16'h0;
    en_b = 1'b0; addr_b = 8'd0; wmask_b = 2'b00; data_in_b = 16'h0;
    en2_a = 1'b0; addr2_a = 8'd0; wmask2_a = 2'b00; din2_a = 16'h0;
    en2_b = 1'b0; addr2_b = 8'd0; wmask2_b = 2'b00; din2_b = 16'h0;
    exp_a = 16'h0; exp_b = 16'h0; exp2_a = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 0);
    check("rst_dout_a", data_out_a, 0);
    check("rst_dout_b", data_out_b, 0);
    check("rst_ready200", ready2, 0);

    reset = 1'b0;
    @(posedge clk); #1;
    check("ready200_first_edge", ready2, 1);
    check("ready_in_sweep", ready, 0);
    wait_ready(1, "sweep_len");
    for (int i = 0; i < 256; i++) mem_m[i] = 16'h0000;

    for (int k = 0; k < 8; k++)
      cyc(1'b1, 8'($urandom_range(255, 0)), 2'b00, 16'h0, 1'b1, 8'($urandom_range(255, 0)), 2'b00, 16'h0);

    cyc(1'b1, 8'd5, 2'b11, 16'hBEEF, 1'b0, 8'd0, 2'b00, 16'h0);
    cyc(1'b1, 8'd5, 2'b10, 16'h1234, 1'b0, 8'd0, 2'b00, 16'h0);
    cyc(1'b0, 8'd0, 2'b00, 16'h0, 1'b1, 8'd5, 2'b00, 16'h0);
    check("byte_mask_merge", data_out_b, 16'h12EF);

    cyc(1'b1, 8'd9, 2'b11, 16'hAAAA, 1'b1, 8'd9, 2'b11, 16'h5555);
    cyc(1'b1, 8'd9, 2'b00, 16'h0, 1'b0, 8'd0, 2'b00, 16'h0);
    check("collide_full", data_out_a, 16'hAAAA);
    cyc(1'b1, 8'd9, 2'b01, 16'hAAAA, 1'b1, 8'd9, 2'b11, 16'h5555);
    cyc(1'b1, 8'd9, 2'b00, 16'h0, 1'b0, 8'd0, 2'b00, 16'h0);
    check("collide_partial", data_out_a, 16'h55AA);

    cyc(1'b1, 8'd3, 2'b11, 16'h0001, 1'b0, 8'd0, 2'b00, 16'h0);
    cyc(1'b1, 8'd3, 2'b11, 16'h0002, 1'b1, 8'd3, 2'b00, 16'h0);
    check("rfw_a", data_out_a, 16'h0001);
    check("rfw_b", data_out_b, 16'h0001);
    cyc(1'b1, 8'd3, 2'b00, 16'h0, 1'b0, 8'd0, 2'b00, 16'h0);
    check("rfw_next", data_out_a, 16'h0002);

    for (int k = 0; k < 400; k++)
      cyc($urandom_range(3, 0) != 0, 8'($urandom_range(15, 0)), 2'($urandom_range(3, 0)), 16'($urandom),
          $urandom_range(3, 0) != 0, 8'($urandom_range(15, 0)), 2'($urandom_range(3, 0)), 16'($urandom));

    for (int i = 0; i < 200; i++) cyc2(8'(i), 2'b11, 16'($urandom));
    cyc2(8'd210, 2'b11, 16'hDEAD);
    check("oob_read_zero", dout2_a, 0);
    cyc2(8'd199, 2'b11, 16'h1999);
    cyc2(8'd199, 2'b00, 16'h0);
    check("last_word", dout2_a, 16'h1999);
    for (int k = 0; k < 150; k++)
      cyc2(8'($urandom_range(230, 180)), 2'($urandom_range(3, 0)), 16'($urandom));
    check("p200_b_idle", dout2_b, 0);

    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("mid_sweep_ready", ready, 0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_ready", ready, 0);
    check("abort_dout_a", data_out_a, 0);
    reset = 1'b0;
    wait_ready(0, "resweep_len");
    for (int i = 0; i < 256; i++) mem_m[i] = 16'h0000;
    exp_a = 16'h0; exp_b = 16'h0;
    for (int i = 0; i < 256; i++)
      cyc(1'b1, 8'(i), 2'b00, 16'h0, 1'b1, 8'(255 - i), 2'b00, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
